// File: rtl/synth_pkg.sv
// Shared types for the synth voice pool.
// Voice and allocator state encodings, volume ceiling.
package synth_pkg;

  typedef enum logic [1:0] {
    FREE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } voice_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  function automatic int unsigned vol_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/voice_envelope.sv
// One synth voice: note, age and a linear
// attack/release volume envelope paced by env_tick.
module voice_envelope
  import synth_pkg::*;
#(
  parameter int NOTE_W = 8,
  parameter int VOL_W  = 4,
  parameter int AGE_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              env_tick,
  input  logic              load,
  input  logic              retrig,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] load_note,
  output voice_state_t      state,
  output logic [VOL_W-1:0]  volume,
  output logic [NOTE_W-1:0] note,
  output logic [AGE_W-1:0]  age
);

  localparam logic [VOL_W-1:0] VMAX =
    VOL_W'(vol_max(VOL_W));
  localparam logic [AGE_W-1:0] AMAX = '1;

  voice_state_t      st_d;
  logic [VOL_W-1:0]  vol_d;
  logic [NOTE_W-1:0] note_d;
  logic [AGE_W-1:0]  age_d;

  // Commit controls win over the envelope tick.
  always_comb begin
    st_d   = state;
    vol_d  = volume;
    note_d = note;
    age_d  = age;
    if (load) begin
      note_d = load_note;
      vol_d  = '0;
      st_d   = ATTACK;
      age_d  = '0;
    end else if (retrig) begin
      st_d  = ATTACK;
      age_d = '0;
    end else if (rel) begin
      st_d = RELEASE;
    end else begin
      if (age_inc && state != FREE &&
          age != AMAX)
        age_d = age + 1'b1;
      if (env_tick) begin
        unique case (state)
          ATTACK: begin
            if (volume == VMAX) begin
              st_d = SUSTAIN;
            end else begin
              vol_d = volume + 1'b1;
              if (volume == VMAX - 1'b1)
                st_d = SUSTAIN;
            end
          end
          SUSTAIN: vol_d = VMAX;
          RELEASE: begin
            if (volume == '0) begin
              st_d = FREE;
            end else begin
              vol_d = volume - 1'b1;
              if (volume == VOL_W'(1))
                st_d = FREE;
            end
          end
          FREE: vol_d = '0;
        endcase
      end
    end
  end

  // Voice register bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FREE;
      volume <= '0;
      note   <= '0;
      age    <= '0;
    end else begin
      state  <= st_d;
      volume <= vol_d;
      note   <= note_d;
      age    <= age_d;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Key-event voice allocator: retrigger, free voice
// or steal oldest, one voice scanned per clock.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = 8,
  parameter int VOL_W  = 4,
  parameter int AGE_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_pressed,
  input  logic [NOTE_W-1:0]        ev_code,
  input  logic                     env_tick,
  output logic [VOICES*NOTE_W-1:0] voice_notes,
  output logic [VOICES*VOL_W-1:0]  voice_volumes,
  output logic [VOICES-1:0]        voice_gate,
  output logic                     steal_pulse
);

  localparam int IW =
    (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(VOICES - 1);

  alloc_state_t a_q, a_d;

  logic [IW-1:0]     idx_q;
  logic              pressed_q;
  logic [NOTE_W-1:0] code_q;
  logic              match_v, free_v, old_v;
  logic [IW-1:0]     match_q, free_q, old_q;
  logic [AGE_W-1:0]  old_age_q;

  voice_state_t      vst  [VOICES];
  logic [VOL_W-1:0]  vvol [VOICES];
  logic [NOTE_W-1:0] vnote[VOICES];
  logic [AGE_W-1:0]  vage [VOICES];

  logic [VOICES-1:0] load_v, retrig_v;
  logic [VOICES-1:0] rel_v, age_v;
  logic              steal_d;

  voice_state_t      sel_st;
  logic [NOTE_W-1:0] sel_note;
  logic [AGE_W-1:0]  sel_age;

  assign ev_ready = (a_q == IDLE);
  assign sel_st   = vst[idx_q];
  assign sel_note = vnote[idx_q];
  assign sel_age  = vage[idx_q];

  // Allocator state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) a_q <= IDLE;
    else          a_q <= a_d;
  end

  // Next-state: accept, walk every voice, commit.
  always_comb begin
    a_d = a_q;
    unique case (a_q)
      IDLE:    if (ev_valid) a_d = SCAN;
      SCAN:    if (idx_q == LAST) a_d = COMMIT;
      COMMIT:  a_d = IDLE;
      default: a_d = IDLE;
    endcase
  end

  // Event latch and running scan results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      pressed_q <= 1'b0;
      code_q    <= '0;
      match_v   <= 1'b0;
      free_v    <= 1'b0;
      old_v     <= 1'b0;
      match_q   <= '0;
      free_q    <= '0;
      old_q     <= '0;
      old_age_q <= '0;
    end else if (a_q == IDLE) begin
      if (ev_valid) begin
        pressed_q <= ev_pressed;
        code_q    <= ev_code;
        idx_q     <= '0;
        match_v   <= 1'b0;
        free_v    <= 1'b0;
        old_v     <= 1'b0;
        match_q   <= '0;
        free_q    <= '0;
        old_q     <= '0;
        old_age_q <= '0;
      end
    end else if (a_q == SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (!match_v && sel_st != FREE &&
          sel_note == code_q) begin
        match_v <= 1'b1;
        match_q <= idx_q;
      end
      if (!free_v && sel_st == FREE) begin
        free_v <= 1'b1;
        free_q <= idx_q;
      end
      if (sel_st != FREE &&
          (!old_v || sel_age > old_age_q)) begin
        old_v     <= 1'b1;
        old_q     <= idx_q;
        old_age_q <= sel_age;
      end
    end
  end

  // Commit decode: one target voice, ages for the rest.
  always_comb begin
    load_v   = '0;
    retrig_v = '0;
    rel_v    = '0;
    age_v    = '0;
    steal_d  = 1'b0;
    if (a_q == COMMIT) begin
      if (pressed_q) begin
        if (match_v) begin
          retrig_v[match_q] = 1'b1;
        end else if (free_v) begin
          load_v[free_q] = 1'b1;
        end else begin
          load_v[old_q] = 1'b1;
          steal_d       = 1'b1;
        end
        age_v = ~(load_v | retrig_v);
      end else if (match_v &&
                   (vst[match_q] == ATTACK ||
                    vst[match_q] == SUSTAIN)) begin
        rel_v[match_q] = 1'b1;
      end
    end
  end

  // Steal strobe, one cycle after the commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) steal_pulse <= 1'b0;
    else          steal_pulse <= steal_d;
  end

  for (genvar i = 0; i < VOICES; i++) begin : g_v
    voice_envelope #(
      .NOTE_W(NOTE_W),
      .VOL_W (VOL_W),
      .AGE_W (AGE_W)
    ) u_env (
      .clk      (clk),
      .reset_n  (reset_n),
      .env_tick (env_tick),
      .load     (load_v[i]),
      .retrig   (retrig_v[i]),
      .rel      (rel_v[i]),
      .age_inc  (age_v[i]),
      .load_note(code_q),
      .state    (vst[i]),
      .volume   (vvol[i]),
      .note     (vnote[i]),
      .age      (vage[i])
    );

    assign voice_notes[i*NOTE_W +: NOTE_W] =
      vnote[i];
    assign voice_volumes[i*VOL_W +: VOL_W] =
      vvol[i];
    assign voice_gate[i] =
      (vst[i] == ATTACK) || (vst[i] == SUSTAIN);
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios
// plus random events against a behavioural model.
module tb_voice_allocator;

  localparam int V  = 4;
  localparam int VM = 15;
  localparam int AM = 15;
  localparam int MF = 0;
  localparam int MA = 1;
  localparam int MS = 2;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_pressed = 1'b0;
  logic [7:0]  ev_code = '0;
  logic        env_tick = 1'b0;
  logic [31:0] voice_notes;
  logic [15:0] voice_volumes;
  logic [3:0]  voice_gate;
  logic        steal_pulse;

  int total = 0;
  int bad   = 0;

  int m_st[V], m_vol[V], m_note[V], m_age[V];
  int s_st[V], s_note[V], s_age[V];
  int ph;
  bit m_pr;
  int m_code;
  bit m_steal;

  voice_allocator #(
    .VOICES(4), .NOTE_W(8), .VOL_W(4), .AGE_W(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_pressed   (ev_pressed),
    .ev_code      (ev_code),
    .env_tick     (env_tick),
    .voice_notes  (voice_notes),
    .voice_volumes(voice_volumes),
    .voice_gate   (voice_gate),
    .steal_pulse  (steal_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_st[i] = MF; m_vol[i] = 0;
      m_note[i] = 0; m_age[i] = 0;
    end
    ph = 0;
    m_steal = 1'b0;
  endtask

  task automatic env_step(inout int st,
                          inout int vol);
    case (st)
      MA: begin
        if (vol < VM) vol++;
        if (vol == VM) st = MS;
      end
      MS: vol = VM;
      MR: begin
        if (vol > 0) vol--;
        if (vol == 0) st = MF;
      end
      default: vol = 0;
    endcase
  endtask

  task automatic model_edge(input bit tick,
                            input bit valid,
                            input bit pr,
                            input int code);
    int n_st[V], n_vol[V], n_note[V], n_age[V];
    bit tgt[V];
    int mt, fr, od, oa, t;
    for (int i = 0; i < V; i++) begin
      n_st[i] = m_st[i]; n_vol[i] = m_vol[i];
      n_note[i] = m_note[i]; n_age[i] = m_age[i];
      tgt[i] = 1'b0;
    end
    m_steal = 1'b0;
    if (ph == V + 1) begin
      mt = -1; fr = -1; od = -1; oa = -1;
      for (int i = 0; i < V; i++) begin
        if (s_st[i] != MF && s_note[i] == m_code
            && mt < 0) mt = i;
        if (s_st[i] == MF && fr < 0) fr = i;
        if (s_st[i] != MF && s_age[i] > oa) begin
          oa = s_age[i]; od = i;
        end
      end
      if (m_pr) begin
        t = (mt >= 0) ? mt : (fr >= 0) ? fr : od;
        for (int i = 0; i < V; i++)
          if (i != t && m_st[i] != MF)
            n_age[i] = (m_age[i] < AM) ?
                       m_age[i] + 1 : AM;
        if (mt < 0) begin
          n_note[t] = m_code;
          n_vol[t] = 0;
        end
        n_st[t] = MA;
        n_age[t] = 0;
        tgt[t] = 1'b1;
        m_steal = (mt < 0 && fr < 0);
      end else if (mt >= 0 &&
                   (m_st[mt] == MA || m_st[mt] == MS)) begin
        n_st[mt] = MR;
        tgt[mt] = 1'b1;
      end
    end
    if (tick)
      for (int i = 0; i < V; i++)
        if (!tgt[i]) env_step(n_st[i], n_vol[i]);
    if (ph >= 1 && ph <= V) begin
      s_st[ph-1] = m_st[ph-1];
      s_note[ph-1] = m_note[ph-1];
      s_age[ph-1] = m_age[ph-1];
      ph++;
    end else if (ph == V + 1) begin
      ph = 0;
    end else if (valid) begin
      m_pr = pr;
      m_code = code;
      ph = 1;
    end
    for (int i = 0; i < V; i++) begin
      m_st[i] = n_st[i]; m_vol[i] = n_vol[i];
      m_note[i] = n_note[i]; m_age[i] = n_age[i];
    end
  endtask

  task automatic check_all();
    logic [31:0] en;
    logic [15:0] ev;
    logic [3:0]  eg;
    for (int i = 0; i < V; i++) begin
      en[i*8 +: 8] = 8'(m_note[i]);
      ev[i*4 +: 4] = 4'(m_vol[i]);
      eg[i] = (m_st[i] == MA || m_st[i] == MS);
    end
    chk("ready", 32'(ev_ready), 32'(ph == 0));
    chk("notes", voice_notes, en);
    chk("vols", 32'(voice_volumes), 32'(ev));
    chk("gate", 32'(voice_gate), 32'(eg));
    chk("steal", 32'(steal_pulse), 32'(m_steal));
  endtask

  task automatic step(input bit tick,
                      input bit valid,
                      input bit pr,
                      input logic [7:0] code);
    env_tick   = tick;
    ev_valid   = valid;
    ev_pressed = pr;
    ev_code    = code;
    @(posedge clk);
    model_edge(tick, valid, pr, int'(code));
    #1;
    check_all();
  endtask

  task automatic ev(input bit pr,
                    input logic [7:0] code,
                    input bit ctick,
                    output int rl,
                    output int sc);
    rl = 0;
    sc = 0;
    step(1'b0, 1'b1, pr, code);
    rl += int'(!ev_ready);
    sc += int'(steal_pulse);
    for (int k = 0; k < V; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      rl += int'(!ev_ready);
      sc += int'(steal_pulse);
    end
    step(ctick, 1'b0, 1'b0, 8'h00);
    rl += int'(!ev_ready);
    sc += int'(steal_pulse);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    rl += int'(!ev_ready);
    sc += int'(steal_pulse);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++)
      step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_all();
    reset_n = 1'b0;
    ev_valid = 1'b0;
    env_tick = 1'b0;
    #2;
    model_reset();
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    int rl, sc;
    bit pend, pr, acc;
    logic [7:0] code;
    logic [7:0] codes[6];
    codes = '{8'h1C, 8'h1B, 8'h23,
              8'h2B, 8'h34, 8'h3B};

    model_reset();
    #12;
    check_all();
    chk("rst_vols", 32'(voice_volumes), 32'h0);
    #2 reset_n = 1'b1;

    ev(1'b1, 8'h1C, 1'b0, rl, sc);
    chk("lat", 32'(rl), 32'd5);
    chk("p0_note", 32'(voice_notes[7:0]), 32'h1C);
    chk("p0_gate", 32'(voice_gate), 32'b0001);
    chk("p0_vol", 32'(voice_volumes[3:0]), 32'd0);
    ticks(15);
    chk("p0_max", 32'(voice_volumes[3:0]), 32'd15);

    reset_all();
    ev(1'b1, 8'h1C, 1'b0, rl, sc);
    ev(1'b1, 8'h1B, 1'b0, rl, sc);
    ev(1'b1, 8'h23, 1'b0, rl, sc);
    ev(1'b1, 8'h2B, 1'b0, rl, sc);
    chk("fill_gate", 32'(voice_gate), 32'hF);
    ev(1'b1, 8'h34, 1'b0, rl, sc);
    chk("steal_cnt", 32'(sc), 32'd1);
    chk("steal_note", 32'(voice_notes[7:0]), 32'h34);
    chk("steal_vol", 32'(voice_volumes[3:0]), 32'd0);

    ticks(15);
    ev(1'b0, 8'h1B, 1'b0, rl, sc);
    chk("rel_gate1", 32'(voice_gate[1]), 32'd0);
    ticks(15);
    chk("rel_vol1", 32'(voice_volumes[7:4]), 32'd0);
    ev(1'b1, 8'h3B, 1'b0, rl, sc);
    chk("reuse_note", 32'(voice_notes[15:8]), 32'h3B);
    chk("reuse_steal", 32'(sc), 32'd0);

    reset_all();
    ev(1'b1, 8'h1C, 1'b0, rl, sc);
    ticks(3);
    ev(1'b1, 8'h1C, 1'b0, rl, sc);
    chk("retrig_vol", 32'(voice_volumes[3:0]), 32'd3);
    chk("retrig_gate", 32'(voice_gate), 32'b0001);

    ev(1'b0, 8'h55, 1'b0, rl, sc);
    chk("nomatch_lat", 32'(rl), 32'd5);
    chk("nomatch_vol", 32'(voice_volumes[3:0]), 32'd3);

    ev(1'b1, 8'h2B, 1'b1, rl, sc);
    chk("ctick_new", 32'(voice_volumes[7:4]), 32'd0);
    chk("ctick_old", 32'(voice_volumes[3:0]), 32'd4);

    step(1'b0, 1'b1, 1'b1, 8'h66);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_gate", 32'(voice_gate), 32'h0);
    #2 reset_n = 1'b1;
    ev(1'b1, 8'h44, 1'b0, rl, sc);
    chk("post_rst", 32'(voice_notes[7:0]), 32'h44);

    pend = 1'b0;
    pr = 1'b0;
    code = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        pr = ($urandom_range(0, 2) != 0);
        code = codes[$urandom_range(0, 5)];
      end
      acc = pend && (ph == 0);
      step($urandom_range(0, 2) == 0,
           pend, pr, code);
      if (acc) pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules a fixed pool of synthesizer voices between PS/2 key events.
- Accepts key press/release events through a valid/ready handshake and assigns each note to a voice: retrigger, free voice, or steal the oldest.
- Runs a per-voice linear attack/release volume envelope paced by an external tick.
- Sits between the ps2_key decode and the Synthesizer block, driving per-voice note codes and volumes in clk_audio.

Parameters:
- VOICES, 4, number of voices in the pool (≥2).
- NOTE_W, 8, width of a key/note code.
- VOL_W, 4, width of each voice volume; VOL_MAX = 2^VOL_W-1.
- AGE_W, 4, width of each per-voice age counter (saturating).

Ports:
- clk, in, 1, audio-domain clock; all logic on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- ev_valid, in, 1, key event present.
- ev_ready, out, 1, allocator can accept an event.
- ev_pressed, in, 1, 1 = key press, 0 = key release.
- ev_code, in, NOTE_W, key code of the event.
- env_tick, in, 1, one-cycle envelope step strobe.
- voice_notes, out, VOICES*NOTE_W, note code per voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- voice_volumes, out, VOICES*VOL_W, current volume per voice, same packing.
- voice_gate, out, VOICES, 1 while a voice is in ATTACK or SUSTAIN.
- steal_pulse, out, 1, one-cycle strobe when a commit stole a busy voice.

Behaviour:
- Reset (asynchronous, reset_n=0) sets:
  - FSM to IDLE, so ev_ready=1.
  - All voices FREE, with note 0, volume 0, age 0.
  - voice_gate=0 and steal_pulse=0.
- Allocator FSM states IDLE, SCAN, COMMIT:
  - ev_ready = (state==IDLE), combinational.
  - IDLE: on ev_valid&&ev_ready, latch ev_pressed and ev_code, clear scan results, set idx=0, go to SCAN.
  - SCAN: one voice per edge, idx 0..VOICES-1. Record the first voice with state≠FREE and note==code (match). Record the first FREE voice. Record the oldest non-FREE voice: largest age, ties go to the lowest index. After idx=VOICES-1, go to COMMIT.
  - COMMIT: apply the update in one edge, then go to IDLE.
- Latency: registered results are visible, and ev_ready returns to 1, VOICES+1 edges after the accepting edge. Events are never dropped; the source holds ev_valid until ev_ready.
- Press, priority order:
  1. Match: voice → ATTACK, volume kept, age 0.
  2. Else lowest FREE voice: note=code, volume 0, ATTACK, age 0.
  3. Else oldest voice is stolen: note=code, volume 0, ATTACK, age 0, steal_pulse=1 for that edge.
  - Every other non-FREE voice: age += 1, saturating at 2^AGE_W-1.
- Release:
  - Match in ATTACK or SUSTAIN → RELEASE.
  - Match already in RELEASE: unchanged.
  - No match: no state change, ages unchanged, still takes the full latency.
- Per-voice envelope, evaluated on env_tick:
  - ATTACK: volume += 1; reaching VOL_MAX → SUSTAIN.
  - SUSTAIN: hold at VOL_MAX.
  - RELEASE: volume -= 1; reaching 0 → FREE. Note is retained but irrelevant.
  - FREE: hold 0.
  - Volume never wraps.
- Simultaneous COMMIT and env_tick: the committed voice takes the commit result and ignores the tick. All other voices apply the tick.
- Events during SCAN/COMMIT are back-pressured (ev_ready=0).
- Envelope ticks continue during SCAN. A voice may become FREE between its scan slot and COMMIT. The scan decision still stands; a steal target that went FREE is simply overwritten.
- voice_gate[i] = state ATTACK or SUSTAIN.
- Reset asserted mid-SCAN aborts the event immediately. No partial commit occurs.

Decomposition:
- synth_pkg holds:
  - typedef voice_state_t {FREE, ATTACK, SUSTAIN, RELEASE}.
  - typedef alloc_state_t {IDLE, SCAN, COMMIT}.
  - The VOL_MAX function/constant.
- One sub-module, voice_envelope, instantiated VOICES times. It holds state, volume, note and age, and has load/retrigger/release/age_inc controls plus env_tick.
- voice_allocator holds the FSM, scan registers and commit decode.

Test Plan:
- Reset, then press 0x1C with no ticks → ev_ready low for exactly 5 cycles (VOICES=4). After that: voice0 note=0x1C, gate=1, volume 0. Then 15 ticks → volume 15, SUSTAIN.
- Press 0x1C, 0x1B, 0x23, 0x2B → voices 0..3 in order. Fifth press 0x34 → voice0 stolen (age 3), steal_pulse high for exactly 1 cycle, voice0 note=0x34, volume 0.
- Voice1 in SUSTAIN, release 0x1B → gate1=0. 15 ticks → volume1=0, FREE. Next press 0x3B → lands in voice1, not a steal.
- Press 0x1C twice with 3 ticks between → same voice retriggered, volume 3 kept, no second voice used, age 0.
- Release 0x55 (never pressed) → all outputs unchanged, ev_ready back after 5 cycles. Hold env_tick high in the COMMIT cycle of a press → target voice volume 0, others advance.
- Assert reset_n=0 during SCAN → all outputs 0 immediately, ev_ready=1. After release, a new press lands in voice0.
